// File: rtl/instr_fetch.sv
// Fetch unit: owns the program counter, drives the ROM address, captures the
// registered ROM word one clock later and queues fetched words for decode.
// A taken branch flushes every wrong-path word and restarts fetch at the target.
//
// state   | meaning
// S_FETCH | normal fetch; issue whenever the queue has room for the word
// S_FLUSH | one cycle after a redirect; queue empty, target issued if enabled
module instr_fetch #(
    parameter int                  ADDR_W     = 10,
    parameter int                  INSTR_W    = 16,
    parameter logic [ADDR_W-1:0]   RESET_IP   = '0,
    parameter logic [INSTR_W-1:0]  NOP_WORD   = '0,
    parameter int                  FIFO_DEPTH = 2
) (
    input  logic               Clock,
    input  logic               Reset,
    output logic [ADDR_W-1:0]  oIp,
    input  logic [INSTR_W-1:0] iInstr,
    input  logic               iEnable,
    output logic               oValid,
    input  logic               iReady,
    output logic [INSTR_W-1:0] oInstr,
    output logic [ADDR_W-1:0]  oInstrIp,
    input  logic               iBranchTaken,
    input  logic [ADDR_W-1:0]  iBranchTarget
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   pc;
    logic                pend;
    logic [ADDR_W-1:0]   pend_ip;
    logic [INSTR_W-1:0]  fifo_instr [FIFO_DEPTH];
    logic [ADDR_W-1:0]   fifo_ip    [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    occupancy;
    logic                pop;
    logic                push;
    logic                issue;

    assign oValid    = (count != '0);
    assign pop       = oValid & iReady;
    // A word landing in the same cycle as a redirect is on the wrong path.
    assign push      = pend & ~iBranchTaken;
    // Slots already spoken for once this cycle's pop and the in-flight word settle.
    assign occupancy = count + CNT_W'(pend) - CNT_W'(pop);

    assign oIp      = pc;
    assign oInstr   = oValid ? fifo_instr[rd_ptr] : NOP_WORD;
    assign oInstrIp = oValid ? fifo_ip[rd_ptr]    : '0;

    // FSM state register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= S_FETCH;
        else       state <= state_nxt;
    end

    // Next state and issue decision; a redirect cancels any issue this cycle
    always_comb begin
        state_nxt = S_FETCH;
        issue     = 1'b0;
        if (iBranchTaken) begin
            state_nxt = S_FLUSH;
        end else if (iEnable) begin
            if (state == S_FLUSH)                        issue = 1'b1;
            else if (occupancy < CNT_W'(FIFO_DEPTH))     issue = 1'b1;
        end
    end

    // Program counter and the one-deep in-flight tracker
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pc      <= RESET_IP;
            pend    <= 1'b0;
            pend_ip <= '0;
        end else if (iBranchTaken) begin
            pc      <= iBranchTarget;
            pend    <= 1'b0;
        end else if (issue) begin
            pc      <= pc + ADDR_W'(1);
            pend    <= 1'b1;
            pend_ip <= pc;
        end else begin
            pend    <= 1'b0;
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (iBranchTaken) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Queue storage; contents are only meaningful below count, so no reset
    always_ff @(posedge Clock) begin
        if (push) begin
            fifo_instr[wr_ptr] <= iInstr;
            fifo_ip[wr_ptr]    <= pend_ip;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: registered ROM model, directed scenarios, then
// randomized traffic compared every cycle against a queue-based reference.
module tb_instr_fetch;

    localparam logic [15:0] NOP = 16'h0000;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [9:0]  oIp;
    logic [15:0] iInstr;
    logic        iEnable;
    logic        oValid;
    logic        iReady;
    logic [15:0] oInstr;
    logic [9:0]  oInstrIp;
    logic        iBranchTaken;
    logic [9:0]  iBranchTarget;

    instr_fetch dut (
        .Clock(Clock), .Reset(Reset), .oIp(oIp), .iInstr(iInstr),
        .iEnable(iEnable), .oValid(oValid), .iReady(iReady), .oInstr(oInstr),
        .oInstrIp(oInstrIp), .iBranchTaken(iBranchTaken), .iBranchTarget(iBranchTarget)
    );

    always #5 Clock = ~Clock;

    logic [15:0] rom [1024];
    int          vectors = 0;
    int          miscompares = 0;

    // Reference: words the decoder should see, in order, by address
    int m_pc;
    bit m_pend;
    int m_pend_ip;
    bit m_flush;
    int q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_pend = 0; m_pend_ip = 0; m_flush = 0;
        q.delete();
    endtask

    task automatic run_cycle(input bit en, input bit rdy, input bit br, input logic [9:0] tgt);
        bit   exp_valid;
        bit   pop;
        bit   issue;
        int   occ;
        logic [9:0] rom_addr;
        @(negedge Clock);
        exp_valid = (q.size() > 0);
        chk("oIp", 32'(oIp), 32'(m_pc));
        chk("oValid", 32'(oValid), 32'(exp_valid));
        if (exp_valid) begin
            chk("oInstr", 32'(oInstr), 32'(rom[q[0]]));
            chk("oInstrIp", 32'(oInstrIp), 32'(q[0]));
        end else begin
            chk("oInstr_nop", 32'(oInstr), 32'(NOP));
        end
        iEnable = en; iReady = rdy; iBranchTaken = br; iBranchTarget = tgt;
        rom_addr = oIp;
        pop = exp_valid && rdy;
        if (br) begin
            q.delete();
            m_pend  = 0;
            m_pc    = int'(tgt);
            m_flush = 1;
        end else begin
            occ   = q.size() + int'(m_pend) - int'(pop);
            issue = en && (m_flush || occ < 2);
            if (pop)    void'(q.pop_front());
            if (m_pend) q.push_back(m_pend_ip);
            if (issue) begin
                m_pend    = 1;
                m_pend_ip = m_pc;
                m_pc      = (m_pc + 1) % 1024;
            end else begin
                m_pend = 0;
            end
            m_flush = 0;
        end
        @(posedge Clock);
        #1 iInstr = rom[rom_addr];
    endtask

    task automatic check_reset_outputs();
        chk("rst_oValid", 32'(oValid), 32'(0));
        chk("rst_oIp", 32'(oIp), 32'(0));
        chk("rst_oInstr", 32'(oInstr), 32'(NOP));
        chk("rst_oInstrIp", 32'(oInstrIp), 32'(0));
    endtask

    task automatic do_reset(input bit randomize_rom);
        @(negedge Clock);
        #2 Reset = 1'b1;
        iEnable = 0; iReady = 0; iBranchTaken = 0; iBranchTarget = '0;
        #1 check_reset_outputs();
        model_reset();
        if (randomize_rom)
            for (int i = 0; i < 1024; i++) rom[i] = 16'($urandom);
        @(posedge Clock);
        @(posedge Clock);
        #2 Reset = 1'b0;
    endtask

    initial begin
        logic [9:0] tgt;
        for (int i = 0; i < 1024; i++) rom[i] = 16'h1000 + 16'(i);
        Reset = 1'b1;
        iInstr = '0; iEnable = 0; iReady = 0; iBranchTaken = 0; iBranchTarget = '0;
        model_reset();
        @(posedge Clock);
        @(negedge Clock);
        check_reset_outputs();
        @(posedge Clock);
        #2 Reset = 1'b0;

        // Streaming from reset, then a 5-cycle stall and resume
        repeat (12) run_cycle(1, 1, 0, '0);
        repeat (5)  run_cycle(1, 0, 0, '0);
        repeat (8)  run_cycle(1, 1, 0, '0);
        // Redirect with a word in flight
        run_cycle(1, 1, 1, 10'h07D);
        repeat (6)  run_cycle(1, 1, 0, '0);
        // Back-to-back redirects, first one alongside a handshake
        run_cycle(1, 1, 1, 10'h010);
        run_cycle(1, 1, 1, 10'h020);
        repeat (6)  run_cycle(1, 1, 0, '0);
        // Address wrap
        run_cycle(1, 1, 1, 10'h3FE);
        repeat (8)  run_cycle(1, 1, 0, '0);
        // Reset with the queue full
        repeat (4)  run_cycle(1, 0, 0, '0);
        do_reset(1'b1);
        repeat (6)  run_cycle(1, 1, 0, '0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) tgt = 10'h3FC + 10'($urandom_range(0, 3));
            else                           tgt = 10'($urandom);
            if (n == 1500) do_reset(1'b1);
            run_cycle($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0,
                      $urandom_range(0, 15) == 0, tgt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
